peristaltic_pump_ctrl: RTL and testbench

Sequential pneumatic driver that turns a stroke-count command into the six-phase closing pattern for three series `valve` instances. Together the valves form an on-chip peristaltic pump. The block sits directly upstream of the valves: `air_out[k]` drives `air_in` of valve k in the pump (v0 nearest the pump inlet, v2 nearest the outlet). It meters a dose of fluid into a downstream `mixer`, `chamber` or `serpentine`.

---
 rtl/peristaltic_pump_ctrl.sv | 177 +++++++++++++++++
 tb/tb_peristaltic_pump_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/peristaltic_pump_ctrl.sv
// peristaltic_pump_ctrl
// Drives three series pneumatic valves (v0 inlet .. v2 outlet) through the
// six-phase peristaltic closing pattern for a commanded number of strokes.
// After the run, or after an abort, the channel is sealed (all valves
// closed) for one hold period before the block reports done and goes idle.
// Every output is a register, so no input reaches an output combinationally.
module peristaltic_pump_ctrl #(
    parameter int STROKE_W = 12,
    parameter int HOLD_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STROKE_W-1:0] cmd_strokes,
    input  logic                cmd_dir,
    input  logic [HOLD_W-1:0]   hold_cycles,
    input  logic                abort,
    output logic [2:0]          air_out,
    output logic                busy,
    output logic                done,
    output logic [STROKE_W-1:0] strokes_left
);

    // Controller states. IDLE waits for a command, RUN steps the valve
    // phases, and SETTLE holds the channel sealed for one hold period.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    localparam logic [2:0] LAST_PHASE = 3'd5;
    localparam logic [2:0] AIR_SEALED = 3'b111;

    logic [1:0]          state;
    logic [2:0]          phase;
    logic                dir;        // latched direction, 1 = reverse
    logic [HOLD_W-1:0]   hold_max;   // H-1 for the active command
    logic [HOLD_W-1:0]   hold_cnt;   // counts H-1 down to 0 within a phase
    logic                handshake;
    logic [HOLD_W-1:0]   hold_load;

    assign handshake = cmd_valid && cmd_ready;

    // A hold request of 0 means the same as 1, so the reload value is
    // never allowed to underflow.
    assign hold_load = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);

    // Valve pattern (v2 v1 v0) for a given phase. 1 = pressurised/closed.
    // Reverse direction mirrors the wave so fluid moves from v2 toward v0.
    function automatic logic [2:0] phase_pattern(input logic rev, input logic [2:0] ph);
        logic [2:0] pat;
        pat = AIR_SEALED;
        if (!rev) begin
            case (ph)
                3'd0:    pat = 3'b001;
                3'd1:    pat = 3'b011;
                3'd2:    pat = 3'b010;
                3'd3:    pat = 3'b110;
                3'd4:    pat = 3'b100;
                3'd5:    pat = 3'b101;
                default: pat = AIR_SEALED;
            endcase
        end else begin
            case (ph)
                3'd0:    pat = 3'b100;
                3'd1:    pat = 3'b110;
                3'd2:    pat = 3'b010;
                3'd3:    pat = 3'b011;
                3'd4:    pat = 3'b001;
                3'd5:    pat = 3'b101;
                default: pat = AIR_SEALED;
            endcase
        end
        return pat;
    endfunction

    // Command sequencing: handshake, phase stepping, stroke counting,
    // abort handling and the sealed settle period.
    // NOTE: every register here uses <= so all of them update together from
    // the values present before the edge; a blocking = would let later
    // statements see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only a handful of registers exist here, so all of them,
            // including the latched command fields, get a reset value.
            state        <= ST_IDLE;
            phase        <= 3'd0;
            dir          <= 1'b0;
            hold_max     <= '0;
            hold_cnt     <= '0;
            air_out      <= AIR_SEALED;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            strokes_left <= '0;
        end else begin
            // done is a single-cycle pulse; only the SETTLE exit raises it.
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // abort is ignored here, including on the handshake edge.
                    if (handshake) begin
                        strokes_left <= cmd_strokes;
                        dir          <= cmd_dir;
                        hold_max     <= hold_load;
                        hold_cnt     <= hold_load;
                        phase        <= 3'd0;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        if (cmd_strokes != '0) begin
                            state   <= ST_RUN;
                            air_out <= phase_pattern(cmd_dir, 3'd0);
                        end else begin
                            // Nothing to pump: seal and settle without moving a valve.
                            state   <= ST_SETTLE;
                            air_out <= AIR_SEALED;
                        end
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        // Seal immediately; the stroke count freezes where it is.
                        state    <= ST_SETTLE;
                        air_out  <= AIR_SEALED;
                        phase    <= 3'd0;
                        hold_cnt <= hold_max;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else begin
                        // Last cycle of the current phase.
                        hold_cnt <= hold_max;
                        if (phase == LAST_PHASE) begin
                            // End of a stroke; the count saturates at zero.
                            if (strokes_left != '0) begin
                                strokes_left <= strokes_left - STROKE_W'(1);
                            end
                            phase <= 3'd0;
                            if (strokes_left <= STROKE_W'(1)) begin
                                state   <= ST_SETTLE;
                                air_out <= AIR_SEALED;
                            end else begin
                                air_out <= phase_pattern(dir, 3'd0);
                            end
                        end else begin
                            phase   <= phase + 3'd1;
                            air_out <= phase_pattern(dir, phase + 3'd1);
                        end
                    end
                end

                ST_SETTLE: begin
                    // Channel stays sealed for H cycles; abort has no effect.
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        done      <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a sealed idle.
                    state     <= ST_IDLE;
                    phase     <= 3'd0;
                    air_out   <= AIR_SEALED;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peristaltic_pump_ctrl.sv
// Testbench for peristaltic_pump_ctrl.
// Expected outputs come from a per-cycle timeline computed arithmetically
// from the command (strokes, hold, direction, abort cycle), compared with
// immediate assertions at every sampled cycle.
module tb_peristaltic_pump_ctrl;

    localparam int SW = 12;
    localparam int HW = 16;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SW-1:0] cmd_strokes;
    logic          cmd_dir;
    logic [HW-1:0] hold_cycles;
    logic          abort;
    logic [2:0]    air_out;
    logic          busy;
    logic          done;
    logic [SW-1:0] strokes_left;

    int checks = 0;
    int fails  = 0;
    int last_sl = 0;

    logic [2:0] fwd_pat [6];
    logic [2:0] rev_pat [6];

    peristaltic_pump_ctrl #(.STROKE_W(SW), .HOLD_W(HW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_strokes  (cmd_strokes),
        .cmd_dir      (cmd_dir),
        .hold_cycles  (hold_cycles),
        .abort        (abort),
        .air_out      (air_out),
        .busy         (busy),
        .done         (done),
        .strokes_left (strokes_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_air, input logic e_busy,
                             input logic e_ready, input logic e_done, input int e_sl);
        check({tag, " air_out"},      32'(air_out),      32'(e_air));
        check({tag, " busy"},         32'(busy),         32'(e_busy));
        check({tag, " cmd_ready"},    32'(cmd_ready),    32'(e_ready));
        check({tag, " done"},         32'(done),         32'(e_done));
        check({tag, " strokes_left"}, 32'(strokes_left), 32'(e_sl));
    endtask

    // Called at a negedge while the DUT is idle and ready (plain idle or the
    // done cycle of a previous command). Presents one command, then walks
    // cycles 1 .. done-cycle, checking each against the expected timeline.
    // Returns at the negedge of the done cycle.
    task automatic run_cmd(input int n, input int hraw, input bit rev,
                           input int abort_at, input string name);
        int h;
        int run_len;
        int frozen;
        int ph;
        logic [2:0] e_air;
        h       = (hraw == 0) ? 1 : hraw;
        run_len = (abort_at > 0) ? abort_at : 6 * n * h;
        frozen  = (abort_at > 0) ? n - (abort_at - 1) / (6 * h) : 0;

        check({name, " ready before handshake"}, 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_strokes = SW'(n);
        cmd_dir     = rev;
        hold_cycles = HW'(hraw);
        abort       = 1'($urandom_range(0, 1));   // must lose to the handshake

        for (int t = 1; t <= run_len + h + 1; t++) begin
            @(negedge clk);
            cmd_valid   = 1'b0;
            cmd_strokes = SW'($urandom);
            cmd_dir     = 1'($urandom);
            hold_cycles = HW'($urandom);
            if (t == abort_at)     abort = 1'b1;
            else if (t > run_len)  abort = 1'($urandom_range(0, 1));
            else                   abort = 1'b0;

            if (t <= run_len) begin
                ph    = ((t - 1) / h) % 6;
                e_air = rev ? rev_pat[ph] : fwd_pat[ph];
                check_all($sformatf("%s run t=%0d", name, t), e_air, 1'b1, 1'b0, 1'b0,
                          n - (t - 1) / (6 * h));
            end else if (t <= run_len + h) begin
                check_all($sformatf("%s settle t=%0d", name, t), 3'b111, 1'b1, 1'b0, 1'b0, frozen);
            end else begin
                check_all($sformatf("%s done t=%0d", name, t), 3'b111, 1'b0, 1'b1, 1'b1, frozen);
            end
        end
        abort   = 1'b0;
        last_sl = frozen;
    endtask

    task automatic idle(input int k, input string name);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            abort     = 1'($urandom_range(0, 1));
            check_all($sformatf("%s idle %0d", name, i), 3'b111, 1'b0, 1'b1, 1'b0, last_sl);
        end
        abort = 1'b0;
    endtask

    initial begin
        int n;
        int h;
        int ab;
        bit rev;

        fwd_pat[0] = 3'b001; fwd_pat[1] = 3'b011; fwd_pat[2] = 3'b010;
        fwd_pat[3] = 3'b110; fwd_pat[4] = 3'b100; fwd_pat[5] = 3'b101;
        rev_pat[0] = 3'b100; rev_pat[1] = 3'b110; rev_pat[2] = 3'b010;
        rev_pat[3] = 3'b011; rev_pat[4] = 3'b001; rev_pat[5] = 3'b101;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_strokes = '0;
        cmd_dir     = 1'b0;
        hold_cycles = '0;
        abort       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all("reset", 3'b111, 1'b0, 1'b1, 1'b0, 0);
        rst_n = 1'b1;
        idle(2, "post_reset");

        // Directed cases
        run_cmd(1, 2, 1'b0, 0, "fwd_n1_h2");
        idle(2, "gap1");
        run_cmd(2, 1, 1'b1, 0, "rev_n2_h1");
        idle(1, "gap2");
        run_cmd(0, 0, 1'b0, 0, "zero_strokes_h0");
        idle(1, "gap3");
        run_cmd(5, 3, 1'b0, 20, "abort_n5_h3");
        idle(2, "gap4");
        run_cmd(1, 1, 1'b0, 0, "b2b_first");
        run_cmd(1, 1, 1'b0, 0, "b2b_second");
        idle(1, "gap5");

        // Asynchronous reset in the middle of a run
        cmd_valid   = 1'b1;
        cmd_strokes = SW'(3);
        cmd_dir     = 1'b0;
        hold_cycles = HW'(2);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check({"mid_run busy"}, 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all("async_reset", 3'b111, 1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        check_all("reset_held", 3'b111, 1'b0, 1'b1, 1'b0, 0);
        rst_n   = 1'b1;
        last_sl = 0;
        idle(3, "after_reset");

        // Randomized commands
        for (int i = 0; i < 30; i++) begin
            n   = $urandom_range(0, 3);
            h   = $urandom_range(0, 4);
            rev = 1'($urandom_range(0, 1));
            ab  = 0;
            if (n > 0 && $urandom_range(0, 2) == 0)
                ab = $urandom_range(1, 6 * n * ((h == 0) ? 1 : h));
            run_cmd(n, h, rev, ab, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1)
                idle($urandom_range(1, 3), $sformatf("rand_gap%0d", i));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
